// File: rtl/brute_force_pkg.sv
// ---------------------------------------------------------------------------
// brute_force_pkg
// Shared constants, types and helpers for the brute_force candidate
// generator and its odometer digit.
//   MAX_LEN    : longest candidate, in characters
//   CHAR_FIRST : first character of the alphabet ('a')
//   CHAR_LAST  : last character of the alphabet ('z')
//   PW_W       : width of the packed candidate string
// ---------------------------------------------------------------------------
package brute_force_pkg;

    localparam int         MAX_LEN    = 16;
    localparam logic [7:0] CHAR_FIRST = 8'h61;
    localparam logic [7:0] CHAR_LAST  = 8'h7A;
    localparam int         PW_W       = 128;

    typedef logic [7:0] pw_char_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } bf_state_t;

    // Anything outside 'a'..'z' starts the leading character at 'a'.
    function automatic pw_char_t clamp_start(input logic [7:0] c);
        if (c < CHAR_FIRST || c > CHAR_LAST) begin
            return CHAR_FIRST;
        end
        return c;
    endfunction

    // A stride of zero would stall the leading character forever.
    function automatic logic [8:0] norm_inc(input logic [2:0] inc);
        if (inc == 3'd0) begin
            return 9'd1;
        end
        return {6'd0, inc};
    endfunction

endpackage

// File: rtl/brute_force_digit.sv
// ---------------------------------------------------------------------------
// brute_force_digit
// One odometer character. Counts 'a'..'z' when a carry arrives and wraps
// back to 'a', producing a carry into the next character. The top can also
// clear it to 0x00, clear it to 'a', or load an arbitrary value (used when
// this position is, or becomes, the leading character).
// Ports:
//   i_clk, i_rst        : clock, async active-high reset
//   i_step              : a step is being applied this cycle
//   i_carry_in          : carry from the next-faster character
//   i_clear_zero        : force 0x00 (position beyond the word)
//   i_clear_to_first    : force 'a'
//   i_load, i_load_val  : load a leading-character value
//   o_char              : current character
//   o_carry_out         : carry into the next-slower character
// Priority: clear_zero > clear_to_first > load > count.
// ---------------------------------------------------------------------------
module brute_force_digit
    import brute_force_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_step,
    input  logic     i_carry_in,
    input  logic     i_clear_zero,
    input  logic     i_clear_to_first,
    input  logic     i_load,
    input  pw_char_t i_load_val,
    output pw_char_t o_char,
    output logic     o_carry_out
);

    pw_char_t r_char;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_char <= '0;
        end else if (i_clear_zero) begin
            r_char <= '0;
        end else if (i_clear_to_first) begin
            r_char <= CHAR_FIRST;
        end else if (i_load) begin
            r_char <= i_load_val;
        end else if (i_step && i_carry_in) begin
            r_char <= (r_char == CHAR_LAST) ? CHAR_FIRST : r_char + 8'd1;
        end
    end

    assign o_char      = r_char;
    assign o_carry_out = i_carry_in && (r_char == CHAR_LAST);

endmodule

// File: rtl/brute_force.sv
// ---------------------------------------------------------------------------
// brute_force
// Sequential candidate-password generator. Each enabled clock steps an
// odometer of 'a'..'z' characters, right-aligned in a 16-byte string.
// The leading character starts at startingPosition and strides by
// increment so that parallel cores partition the search space.
// Ports:
//   clk              : rising-edge clock
//   reset            : async active-high reset
//   enable           : advance one candidate per clock while high
//   startingPosition : first leading character (clamped to 'a'..'z')
//   increment        : leading-character stride (0 behaves as 1)
//   wordLength       : valid characters in password (0 = not loaded)
//   password         : candidate, byte 0 = [7:0] = fastest character
// Configuration macro:
//   BRUTE_FORCE_WRAP_EN : when defined, overflow past 16 characters
//                         restarts at a single-character word; otherwise
//                         the final candidate is held until reset.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_EMPTY  | after reset, wordLength 0; first enabled clock loads
// ST_RUN    | stepping the odometer on every enabled clock
// ST_FROZEN | 16-char space exhausted, outputs held until reset
// ---------------------------------------------------------------------------
module brute_force
    import brute_force_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      startingPosition,
    input  logic [2:0]      increment,
    output logic [7:0]      wordLength,
    output logic [PW_W-1:0] password
);

    bf_state_t r_state;
    bf_state_t w_state_nxt;

    logic [7:0] r_len;
    pw_char_t   r_top;

    pw_char_t   w_bytes [MAX_LEN];
    logic [MAX_LEN-2:0] w_cin;
    logic [MAX_LEN-2:0] w_cout;

    pw_char_t   w_start;
    logic [8:0] w_inc;
    logic [3:0] w_lead_idx;
    pw_char_t   w_lead_char;
    logic       w_lead_carry;
    logic [8:0] w_sum;
    logic       w_overflow;

    logic w_do_load;
    logic w_do_step;
    logic w_do_lead;
    logic w_do_grow;

    assign w_start = clamp_start(startingPosition);
    assign w_inc   = norm_inc(increment);

    // Byte 15 can only ever be the leading character, so it is held here
    // rather than in a digit instance.
    assign w_bytes[MAX_LEN-1] = r_top;

    // Leading index is L-1; for L=16 the 4-bit subtraction lands on 15.
    assign w_lead_idx  = r_len[3:0] - 4'd1;
    assign w_lead_char = w_bytes[w_lead_idx];

    // The carry ripples only through non-leading positions; the leading
    // character is handled by the stride logic below.
    always_comb begin
        logic v_run;
        v_run = 1'b1;
        w_cin = '0;
        for (int k = 0; k < MAX_LEN - 1; k++) begin
            w_cin[k] = v_run && (8'(k + 1) < r_len);
            v_run    = v_run && (w_bytes[k] == CHAR_LAST);
        end
    end

    assign w_lead_carry = (w_lead_idx == 4'd0) ? 1'b1 : w_cout[w_lead_idx - 4'd1];

    // Nine bits so a stride past 'z' is seen rather than wrapping.
    assign w_sum      = {1'b0, w_lead_char} + w_inc;
    assign w_overflow = (w_sum > {1'b0, CHAR_LAST});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_step   = 1'b0;
        w_do_lead   = 1'b0;
        w_do_grow   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (enable) begin
                    w_do_load   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (!w_lead_carry) begin
                        w_do_step = 1'b1;
                    end else if (!w_overflow) begin
                        w_do_step = 1'b1;
                        w_do_lead = 1'b1;
                    end else if (r_len != 8'(MAX_LEN)) begin
                        w_do_step = 1'b1;
                        w_do_grow = 1'b1;
                    end else begin
`ifdef BRUTE_FORCE_WRAP_EN
                        w_do_load = 1'b1;
`else
                        w_state_nxt = ST_FROZEN;
`endif
                    end
                end
            end
            ST_FROZEN: begin
                w_state_nxt = ST_FROZEN;
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= '0;
            r_top <= '0;
        end else if (w_do_load) begin
            r_len <= 8'd1;
            r_top <= '0;
        end else if (w_do_grow) begin
            r_len <= r_len + 8'd1;
            if (r_len == 8'(MAX_LEN - 1)) begin
                r_top <= w_start;
            end
        end else if (w_do_lead && (r_len == 8'(MAX_LEN))) begin
            r_top <= w_sum[7:0];
        end
    end

    for (genvar k = 0; k < MAX_LEN - 1; k++) begin : g_digit
        localparam logic [7:0] K = 8'(k);

        logic     w_clr_zero;
        logic     w_clr_first;
        logic     w_load;
        pw_char_t w_load_val;

        // Byte 0 takes startingPosition on a load; all others go to 0x00.
        assign w_clr_zero  = w_do_load && (k != 0);
        // On growth the old leading byte and everything below become 'a'.
        assign w_clr_first = w_do_grow && (K < r_len);
        assign w_load      = (w_do_load && (k == 0))
                           || (w_do_lead && ((K + 8'd1) == r_len))
                           || (w_do_grow && (K == r_len));
        assign w_load_val  = w_do_lead ? w_sum[7:0] : w_start;

        brute_force_digit u_digit (
            .i_clk            (clk),
            .i_rst            (reset),
            .i_step           (w_do_step),
            .i_carry_in       (w_cin[k]),
            .i_clear_zero     (w_clr_zero),
            .i_clear_to_first (w_clr_first),
            .i_load           (w_load),
            .i_load_val       (w_load_val),
            .o_char           (w_bytes[k]),
            .o_carry_out      (w_cout[k])
        );
    end

    for (genvar j = 0; j < MAX_LEN; j++) begin : g_pack
        assign password[j*8 +: 8] = w_bytes[j];
    end

    assign wordLength = r_len;

endmodule

// File: tb/tb_brute_force.sv
// ---------------------------------------------------------------------------
// tb_brute_force
// Table of directed vectors with hand-derived results, hand-written
// sequences for hold / async reset / 16-character overflow, and randomized
// runs compared every cycle against a reference model that treats the
// candidate as a base-26 count below a strided leading character.
// ---------------------------------------------------------------------------
module tb_brute_force;
    import brute_force_pkg::*;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [7:0]   start_pos;
    logic [2:0]   inc;
    logic [7:0]   word_len;
    logic [127:0] pw;

    int n_tests;
    int n_fail;

    int         m_len;
    logic [7:0] m_ch [16];
    bit         m_done;

    typedef struct {
        logic [7:0]   sp;
        logic [2:0]   inc;
        int           cycles;
        logic [7:0]   len;
        logic [127:0] pw;
    } vec_t;

    vec_t vecs [16];

    brute_force dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .startingPosition (start_pos),
        .increment        (inc),
        .wordLength       (word_len),
        .password         (pw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        m_len  = 0;
        m_done = 1'b0;
        for (int k = 0; k < 16; k++) m_ch[k] = 8'h00;
    endfunction

    function automatic void m_load(input int s);
        m_len = 1;
        for (int k = 0; k < 16; k++) m_ch[k] = 8'h00;
        m_ch[0] = 8'(s);
    endfunction

    function automatic void m_step(input int sp, input int in_c);
        int  s;
        int  d;
        int  k;
        bit  all_z;
        s = (sp < 97 || sp > 122) ? 97 : sp;
        d = (in_c == 0) ? 1 : in_c;
        if (m_done) return;
        if (m_len == 0) begin
            m_load(s);
            return;
        end
        all_z = 1'b1;
        for (int i = 0; i < m_len - 1; i++) if (m_ch[i] != 8'h7a) all_z = 1'b0;
        if (!all_z) begin
            k = 0;
            while (m_ch[k] == 8'h7a) begin
                m_ch[k] = 8'h61;
                k++;
            end
            m_ch[k] = m_ch[k] + 8'd1;
            return;
        end
        if (int'(m_ch[m_len-1]) + d <= 122) begin
            for (int i = 0; i < m_len - 1; i++) m_ch[i] = 8'h61;
            m_ch[m_len-1] = 8'(int'(m_ch[m_len-1]) + d);
            return;
        end
        if (m_len < 16) begin
            for (int i = 0; i < m_len; i++) m_ch[i] = 8'h61;
            m_ch[m_len] = 8'(s);
            m_len++;
            return;
        end
`ifdef BRUTE_FORCE_WRAP_EN
        m_load(s);
`else
        m_done = 1'b1;
`endif
    endfunction

    function automatic logic [127:0] m_pw();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) if (k < m_len) r[k*8 +: 8] = m_ch[k];
        return r;
    endfunction

    task automatic check_exp(input string name, input logic [7:0] e_len, input logic [127:0] e_pw);
        n_tests++;
        if (word_len !== e_len || pw !== e_pw) begin
            n_fail++;
            $display("FAIL %s: got wordLength=%0d password=%h, expected wordLength=%0d password=%h",
                     name, word_len, pw, e_len, e_pw);
        end
    endtask

    task automatic check(input string name);
        check_exp(name, 8'(m_len), m_pw());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset && enable) m_step(int'(start_pos), int'(inc));
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        check("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic force_full();
        force dut.r_len = 8'd16;
        force dut.r_top = 8'h7a;
        force dut.g_digit[0].u_digit.r_char  = 8'h7a;
        force dut.g_digit[1].u_digit.r_char  = 8'h7a;
        force dut.g_digit[2].u_digit.r_char  = 8'h7a;
        force dut.g_digit[3].u_digit.r_char  = 8'h7a;
        force dut.g_digit[4].u_digit.r_char  = 8'h7a;
        force dut.g_digit[5].u_digit.r_char  = 8'h7a;
        force dut.g_digit[6].u_digit.r_char  = 8'h7a;
        force dut.g_digit[7].u_digit.r_char  = 8'h7a;
        force dut.g_digit[8].u_digit.r_char  = 8'h7a;
        force dut.g_digit[9].u_digit.r_char  = 8'h7a;
        force dut.g_digit[10].u_digit.r_char = 8'h7a;
        force dut.g_digit[11].u_digit.r_char = 8'h7a;
        force dut.g_digit[12].u_digit.r_char = 8'h7a;
        force dut.g_digit[13].u_digit.r_char = 8'h7a;
        force dut.g_digit[14].u_digit.r_char = 8'h7a;
        #1;
        release dut.r_len;
        release dut.r_top;
        release dut.g_digit[0].u_digit.r_char;
        release dut.g_digit[1].u_digit.r_char;
        release dut.g_digit[2].u_digit.r_char;
        release dut.g_digit[3].u_digit.r_char;
        release dut.g_digit[4].u_digit.r_char;
        release dut.g_digit[5].u_digit.r_char;
        release dut.g_digit[6].u_digit.r_char;
        release dut.g_digit[7].u_digit.r_char;
        release dut.g_digit[8].u_digit.r_char;
        release dut.g_digit[9].u_digit.r_char;
        release dut.g_digit[10].u_digit.r_char;
        release dut.g_digit[11].u_digit.r_char;
        release dut.g_digit[12].u_digit.r_char;
        release dut.g_digit[13].u_digit.r_char;
        release dut.g_digit[14].u_digit.r_char;
        m_len  = 16;
        m_done = 1'b0;
        for (int k = 0; k < 16; k++) m_ch[k] = 8'h7a;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        start_pos = 8'h61;
        inc       = 3'd1;
        m_reset();

        vecs[0]  = '{8'h61, 3'd1,   1, 8'd1, 128'h61};
        vecs[1]  = '{8'h61, 3'd1,  26, 8'd1, 128'h7a};
        vecs[2]  = '{8'h61, 3'd1,  27, 8'd2, 128'h6161};
        vecs[3]  = '{8'h61, 3'd1,  28, 8'd2, 128'h6162};
        vecs[4]  = '{8'h62, 3'd3,   9, 8'd1, 128'h7a};
        vecs[5]  = '{8'h62, 3'd3,  10, 8'd2, 128'h6261};
        vecs[6]  = '{8'h62, 3'd3,  36, 8'd2, 128'h6561};
        vecs[7]  = '{8'h62, 3'd3, 244, 8'd3, 128'h626161};
        vecs[8]  = '{8'h61, 3'd2,  13, 8'd1, 128'h79};
        vecs[9]  = '{8'h61, 3'd2,  14, 8'd2, 128'h6161};
        vecs[10] = '{8'h30, 3'd0,   1, 8'd1, 128'h61};
        vecs[11] = '{8'h30, 3'd0,   3, 8'd1, 128'h63};
        vecs[12] = '{8'h7a, 3'd5,   2, 8'd2, 128'h7a61};
        vecs[13] = '{8'h7a, 3'd5,  28, 8'd3, 128'h7a6161};
        vecs[14] = '{8'h61, 3'd7,   5, 8'd2, 128'h6161};
        vecs[15] = '{8'h7b, 3'd1,   1, 8'd1, 128'h61};

        repeat (2) @(posedge clk);
        #1;
        check_exp("reset_state", 8'd0, 128'h0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            check_exp("idle_unloaded", 8'd0, 128'h0);
        end

        for (int v = 0; v < 16; v++) begin
            enable    = 1'b0;
            start_pos = vecs[v].sp;
            inc       = vecs[v].inc;
            do_reset();
            enable = 1'b1;
            for (int c = 0; c < vecs[v].cycles; c++) tick();
            check_exp($sformatf("vec%0d", v), vecs[v].len, vecs[v].pw);
        end

        // Enable low mid-run holds, then resumes exactly where it stopped.
        enable    = 1'b0;
        start_pos = 8'h61;
        inc       = 3'd1;
        do_reset();
        enable = 1'b1;
        repeat (30) begin
            tick();
            check("run");
        end
        enable = 1'b0;
        repeat (5) begin
            tick();
            check_exp("hold", 8'd2, 128'h6164);
        end
        enable = 1'b1;
        repeat (3) begin
            tick();
            check("resume");
        end

        // Reset pulse mid-run clears at once; the next enabled edge reloads.
        do_reset();
        tick();
        check_exp("reload", 8'd1, 128'h61);
        tick();
        check_exp("reload_step", 8'd1, 128'h62);

        // Sixteen characters, all 'z': the next step overflows.
        enable    = 1'b0;
        start_pos = 8'h63;
        inc       = 3'd1;
        do_reset();
        enable = 1'b1;
        tick();
        check("pre_force_load");
        force_full();
        check("forced_full");
        tick();
`ifdef BRUTE_FORCE_WRAP_EN
        check_exp("overflow", 8'd1, 128'h63);
`else
        check_exp("overflow", 8'd16, {16{8'h7a}});
`endif
        inc = 3'd0;
        repeat (3) begin
            tick();
            check("after_overflow");
        end

        // Randomized runs, including out-of-range inputs and mid-run changes.
        for (int seg = 0; seg < 6; seg++) begin
            enable    = 1'b0;
            start_pos = ($urandom_range(0, 1) == 0) ? 8'(8'h61 + $urandom_range(0, 25))
                                                    : 8'($urandom_range(0, 255));
            inc       = 3'($urandom_range(0, 7));
            do_reset();
            for (int c = 0; c < 300; c++) begin
                enable = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) begin
                    start_pos = 8'(8'h61 + $urandom_range(0, 25));
                    inc       = 3'($urandom_range(0, 7));
                end
                tick();
                check("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
